// File: rtl/checkbits_mon_pkg.sv
// Shared types and widths for the firmware checkpoint monitor.
// Holds the FSM state encoding and the elaboration-time parameter sanity check.
package checkbits_mon_pkg;

    localparam int LAT_W = 32;
    localparam int CHK_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRACK = 3'd1,
        PASS  = 3'd2,
        FAIL  = 3'd3,
        TOUT  = 3'd4
    } mon_state_e;

    function automatic bit params_ok(input int depth, input int stable_cyc);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (stable_cyc >= 1);
    endfunction

endpackage

// File: rtl/checkbits_stable_filter.sv
// Glitch filter: one input register, then a run counter that flags a word once it has held long enough.
// acc_valid is high for one cycle, STABLE_CYC cycles after the word first lands in the register; no backpressure.
module checkbits_stable_filter
    import checkbits_mon_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [CHK_W-1:0] mon_word,
    output logic             acc_valid,
    output logic [CHK_W-1:0] acc_word
);

    localparam int                CNT_W   = $clog2(STABLE_CYC + 2);
    localparam logic [CNT_W-1:0]  CNT_HIT = CNT_W'(STABLE_CYC);

    logic [CHK_W-1:0] word_q;
    logic [CNT_W-1:0] stable_cnt;

    // Counter parks at STABLE_CYC+1 so a word held forever is accepted only once.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            word_q     <= '0;
            stable_cnt <= '0;
        end else begin
            word_q <= mon_word;
            if (mon_word != word_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt <= CNT_HIT) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    assign acc_valid = (stable_cnt == CNT_HIT);
    assign acc_word  = word_q;

endmodule

// File: rtl/checkbits_seq_monitor.sv
// Matches filtered mprj_io[31:16] checkpoints against a programmed sequence; reports pass/fail/timeout and hit latency.
// Hit appears STABLE_CYC+1 cycles after a new word is first sampled; no backpressure, start/exp_we ignored while busy.
module checkbits_seq_monitor
    import checkbits_mon_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 500000,
    parameter int STRICT      = 0
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic [CHK_W-1:0]         mon_word,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [CHK_W-1:0]         exp_data,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic                     start,
    output logic                     busy,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] hit_idx,
    output logic [LAT_W-1:0]         lat_cycles,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout
);

    localparam int                AW        = $clog2(DEPTH);
    localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]       CNT_ONE   = 1;
    localparam bit                STRICT_EN = (STRICT != 0);

    if (!params_ok(DEPTH, STABLE_CYC) || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("checkbits_seq_monitor: DEPTH must be a power of 2 >= 2, STABLE_CYC and TIMEOUT_CYC >= 1");
    end

    mon_state_e       state;
    logic [AW-1:0]    idx;
    logic [AW:0]      count_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CHK_W-1:0] exp_tab [DEPTH];

    logic             acc_valid;
    logic [CHK_W-1:0] acc_word;
    logic             match;
    logic             last_entry;

    checkbits_stable_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clock     (clock),
        .resetb    (resetb),
        .mon_word  (mon_word),
        .acc_valid (acc_valid),
        .acc_word  (acc_word)
    );

    // Table survives reset so a restart does not need a reload.
    always_ff @(posedge clock) begin
        if (exp_we && state == IDLE) begin
            exp_tab[exp_addr] <= exp_data;
        end
    end

    assign match      = acc_valid && (acc_word == exp_tab[idx]);
    assign last_entry = ({1'b0, idx} == count_q - CNT_ONE);
    assign lat_inc    = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);
    assign busy       = (state == TRACK);

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state      <= IDLE;
            idx        <= '0;
            count_q    <= '0;
            lat_cnt    <= '0;
            tmo_cnt    <= '0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            lat_cycles <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                TRACK: begin
                    // Priority: hit, then strict mismatch, then timeout.
                    if (match) begin
                        hit        <= 1'b1;
                        hit_idx    <= idx;
                        lat_cycles <= lat_inc;
                        lat_cnt    <= '0;
                        tmo_cnt    <= '0;
                        if (last_entry) begin
                            state <= PASS;
                            pass  <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (acc_valid && STRICT_EN) begin
                        state <= FAIL;
                        fail  <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= TOUT;
                        timeout <= 1'b1;
                    end else begin
                        lat_cnt <= lat_inc;
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    if (start) begin
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                        timeout <= 1'b0;
                        idx     <= '0;
                        lat_cnt <= '0;
                        tmo_cnt <= '0;
                        count_q <= exp_count;
                        if (exp_count == '0) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
            endcase
        end
    end

endmodule
